// File: rtl/custom_axi_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite register file bridge.
// Holds the transaction FSM states, AXI response codes and default parameter values.
package custom_axi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_STROBE,
    WR_WAIT,
    WR_RESP,
    RD_RESP
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int DEF_NUM_REGS    = 3;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 4;
  localparam int DEF_ACK_TIMEOUT = 16;

endpackage

// File: rtl/custom_axi_regfile.sv
// AXI4-Lite slave bridging single-word accesses to an IP-side strobe/ack register bank.
// One transaction in flight; writes merge byte strobes over a write shadow, reads return a sampled shadow.
module custom_axi_regfile
  import custom_axi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ADDR_W-1:0]          s_awaddr,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [DATA_W-1:0]          s_wdata,
  input  logic [DATA_W/8-1:0]        s_wstrb,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  output logic [1:0]                 s_bresp,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  input  logic [ADDR_W-1:0]          s_araddr,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [DATA_W-1:0]          reg2ip_data,
  output logic [NUM_REGS-1:0]        reg2ip_en,
  input  logic [NUM_REGS-1:0]        reg2ip_ack,
  input  logic [NUM_REGS*DATA_W-1:0] ip2reg_data,
  input  logic [NUM_REGS-1:0]        ip2reg_valid,
  output state_t                     o_dbg_state
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(ACK_TIMEOUT) + 1;

  state_t               r_state, w_next;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_W-1:0]    r_wdata;
  logic [STRB_W-1:0]    r_wstrb;
  logic [1:0]           r_bresp, r_rresp;
  logic [DATA_W-1:0]    r_rdata;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_W-1:0]    r_wr_shadow [NUM_REGS];
  logic [DATA_W-1:0]    r_rd_shadow [NUM_REGS];

  logic                 w_wr_pair, w_idle, w_wr_acc, w_rd_acc;
  logic                 w_idx_ok, w_ar_ok, w_ack, w_timeout, w_strobe;
  logic [IDX_W-1:0]     w_ar_idx;
  logic [DATA_W-1:0]    w_old, w_merged, w_rd_fwd;
  logic                 w_unused_addr_lsbs;

  // Handshake: a channel transfers on a cycle where valid and ready are both high.
  // AW and W are accepted only together; once raised, bvalid/rvalid and their payload
  // stay constant until the matching ready completes the transfer.
  assign w_wr_pair = s_awvalid && s_wvalid;
  assign w_idle    = (r_state == IDLE) && !rst_i;
  assign w_wr_acc  = w_idle && w_wr_pair;
  assign w_rd_acc  = w_idle && s_arvalid && !w_wr_pair;
  assign w_idx_ok  = int'(r_idx) < NUM_REGS;
  assign w_ar_idx  = s_araddr[ADDR_W-1:2];
  assign w_ar_ok   = int'(w_ar_idx) < NUM_REGS;
  assign w_ack     = w_idx_ok && reg2ip_ack[r_idx];
  assign w_timeout = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign w_strobe  = (r_state == WR_STROBE) && w_idx_ok;
  assign w_unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  // Read data is the shadow value as it stands once RD_RESP is entered, so a
  // same-cycle IP update is forwarded rather than missed.
  always_comb begin
    w_old    = '0;
    w_rd_fwd = '0;
    w_merged = '0;
    if (w_idx_ok) w_old = r_wr_shadow[r_idx];
    if (w_ar_ok) begin
      w_rd_fwd = ip2reg_valid[w_ar_idx] ? ip2reg_data[int'(w_ar_idx)*DATA_W +: DATA_W]
                                        : r_rd_shadow[w_ar_idx];
    end
    for (int b = 0; b < STRB_W; b++) begin
      w_merged[8*b +: 8] = r_wstrb[b] ? r_wdata[8*b +: 8] : w_old[8*b +: 8];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_wr_acc) w_next = WR_STROBE;
                 else if (w_rd_acc) w_next = RD_RESP;
      WR_STROBE: w_next = w_idx_ok ? WR_WAIT : WR_RESP;
      WR_WAIT:   if (w_ack || w_timeout) w_next = WR_RESP;
      WR_RESP:   if (s_bready) w_next = IDLE;
      RD_RESP:   if (s_rready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_bresp <= AXI_RESP_OKAY;
      r_rresp <= AXI_RESP_OKAY;
      r_rdata <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_wr_shadow[i] <= '0;
        r_rd_shadow[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ip2reg_valid[i]) r_rd_shadow[i] <= ip2reg_data[i*DATA_W +: DATA_W];
      end
      case (r_state)
        IDLE: begin
          if (w_wr_acc) begin
            r_idx   <= s_awaddr[ADDR_W-1:2];
            r_wdata <= s_wdata;
            r_wstrb <= s_wstrb;
          end else if (w_rd_acc) begin
            r_idx   <= w_ar_idx;
            r_rdata <= w_ar_ok ? w_rd_fwd : '0;
            r_rresp <= w_ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          end
        end
        WR_STROBE: begin
          r_cnt <= '0;
          if (w_idx_ok) r_wr_shadow[r_idx] <= w_merged;
          else r_bresp <= AXI_RESP_SLVERR;
        end
        WR_WAIT: begin
          if (w_ack) r_bresp <= AXI_RESP_OKAY;
          else if (w_timeout) r_bresp <= AXI_RESP_SLVERR;
          else r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    reg2ip_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg2ip_en[i] = w_strobe && (int'(r_idx) == i);
    end
  end

  assign reg2ip_data = w_strobe ? w_merged : '0;
  assign s_awready   = w_wr_acc;
  assign s_wready    = w_wr_acc;
  assign s_arready   = w_rd_acc;
  assign s_bvalid    = (r_state == WR_RESP);
  assign s_bresp     = s_bvalid ? r_bresp : AXI_RESP_OKAY;
  assign s_rvalid    = (r_state == RD_RESP);
  assign s_rdata     = r_rdata;
  assign s_rresp     = r_rresp;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_custom_axi_regfile.sv
// Bench for custom_axi_regfile: directed vector table, hand-written corner sequences,
// and randomized transactions scored against a transaction-level register model.
module tb_custom_axi_regfile;
  import custom_axi_regfile_pkg::*;

  localparam int NUM_REGS    = 3;
  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int STRB_W      = DATA_W / 8;

  logic                       clk_i = 1'b0;
  logic                       rst_i;
  logic [ADDR_W-1:0]          s_awaddr, s_araddr;
  logic                       s_awvalid, s_awready, s_wvalid, s_wready;
  logic [DATA_W-1:0]          s_wdata, s_rdata;
  logic [STRB_W-1:0]          s_wstrb;
  logic [1:0]                 s_bresp, s_rresp;
  logic                       s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [DATA_W-1:0]          reg2ip_data;
  logic [NUM_REGS-1:0]        reg2ip_en, reg2ip_ack, ip2reg_valid;
  logic [NUM_REGS*DATA_W-1:0] ip2reg_data;
  state_t                     o_dbg_state;

  custom_axi_regfile #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .reg2ip_data(reg2ip_data), .reg2ip_en(reg2ip_en), .reg2ip_ack(reg2ip_ack),
    .ip2reg_data(ip2reg_data), .ip2reg_valid(ip2reg_valid),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_wr [NUM_REGS];
  logic [DATA_W-1:0] m_rd [NUM_REGS];

  typedef struct {
    bit                  is_rd;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [STRB_W-1:0]   strb;
    int                  ack_dly;
    logic [NUM_REGS-1:0] exp_en;
    logic [DATA_W-1:0]   exp_val;
    logic [1:0]          exp_resp;
    int                  exp_lat;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] d,
                                              input logic [STRB_W-1:0] s);
    merge = old;
    for (int b = 0; b < STRB_W; b++) if (s[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_handshake"}, 32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                                    s_bresp, s_rresp, reg2ip_en}), '0);
    check({tag, "_rdata"}, s_rdata, '0);
    check({tag, "_reg2ip_data"}, reg2ip_data, '0);
    check({tag, "_state"}, 32'(o_dbg_state), 32'(IDLE));
  endtask

  task automatic pulse_ip(input logic [NUM_REGS-1:0] v, input logic [NUM_REGS*DATA_W-1:0] d);
    ip2reg_valid = v;
    ip2reg_data  = d;
    step();
    ip2reg_valid = '0;
    for (int i = 0; i < NUM_REGS; i++) if (v[i]) m_rd[i] = d[i*DATA_W +: DATA_W];
  endtask

  // ack_dly: >0 ack that many cycles after the strobe cycle, -1 never, -2 ack on other bits only
  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [STRB_W-1:0] strb, input int ack_dly, input int hold,
                          output logic [NUM_REGS-1:0] en_seen, output logic [DATA_W-1:0] data_seen,
                          output logic [1:0] resp, output int lat, output bit ok);
    int cyc, en_cyc, pulses, idx;
    bit got;
    logic [NUM_REGS-1:0] onehot;
    idx = int'(addr[ADDR_W-1:2]);
    onehot = '0;
    if (idx < NUM_REGS) onehot[idx] = 1'b1;
    en_seen = '0; data_seen = '0; resp = '0; lat = 0; ok = 1;
    cyc = 0; en_cyc = -100; pulses = 0; got = 0;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    if (!(s_awready && s_wready)) ok = 0;
    while (!got && cyc < 100) begin
      step();
      cyc++;
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      reg2ip_ack = '0;
      if (reg2ip_en != '0) begin
        pulses++;
        en_seen |= reg2ip_en;
        data_seen = reg2ip_data;
        en_cyc = cyc;
      end else if (reg2ip_data != '0) ok = 0;
      if (s_bvalid) begin
        got = 1; lat = cyc; resp = s_bresp;
      end else if (ack_dly == -2 && en_cyc > 0) reg2ip_ack = ~onehot;
      else if (ack_dly > 0 && cyc == en_cyc + ack_dly) reg2ip_ack = onehot;
    end
    if (!got || pulses > 1) ok = 0;
    repeat (hold) begin
      step();
      if (!s_bvalid || s_bresp !== resp || reg2ip_en != '0) ok = 0;
    end
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    if (s_bvalid) ok = 0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input int hold,
                         output logic [DATA_W-1:0] rdata, output logic [1:0] resp,
                         output int lat, output bit ok);
    int cyc;
    bit got;
    rdata = '0; resp = '0; lat = 0; ok = 1; cyc = 0; got = 0;
    s_araddr = addr; s_arvalid = 1'b1;
    #1;
    if (!s_arready) ok = 0;
    while (!got && cyc < 100) begin
      step();
      cyc++;
      s_arvalid = 1'b0;
      if (reg2ip_en != '0) ok = 0;
      if (s_rvalid) begin
        got = 1; lat = cyc; rdata = s_rdata; resp = s_rresp;
      end
    end
    if (!got) ok = 0;
    repeat (hold) begin
      step();
      if (!s_rvalid || s_rdata !== rdata || s_rresp !== resp) ok = 0;
    end
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    if (s_rvalid) ok = 0;
  endtask

  // ---------------- test sequence ----------------
  logic [NUM_REGS-1:0]        en_seen, rv;
  logic [DATA_W-1:0]          dseen, rdat, wd, ev;
  logic [ADDR_W-1:0]          ra;
  logic [STRB_W-1:0]          rs;
  logic [1:0]                 resp, eresp;
  logic [NUM_REGS*DATA_W-1:0] rdd;
  int                         lat, ack, pulses, bv, idx, elat;
  bit                         ok, stable;

  initial begin
    rst_i = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    reg2ip_ack = '0; ip2reg_data = '0; ip2reg_valid = '0;
    for (int i = 0; i < NUM_REGS; i++) begin m_wr[i] = '0; m_rd[i] = '0; end
    step();
    step();
    check_idle("reset");
    rst_i = 1'b0;
    step();

    // IP-side samples: slice 2 = 0x12345678, slice 0 = 0x0F0F0F0F, slice 1 not valid
    pulse_ip(3'b101, {32'h12345678, 32'hFFFF_0000, 32'h0F0F0F0F});

    vecs[0]  = '{0, 4'h4, 32'hDEADBEEF, 4'hF,  1, 3'b010, 32'hDEADBEEF, AXI_RESP_OKAY,   3};
    vecs[1]  = '{0, 4'h4, 32'h000000AA, 4'h1,  1, 3'b010, 32'hDEADBEAA, AXI_RESP_OKAY,   3};
    vecs[2]  = '{0, 4'hC, 32'h11111111, 4'hF, -1, 3'b000, 32'h00000000, AXI_RESP_SLVERR, 2};
    vecs[3]  = '{0, 4'h0, 32'hCAFEF00D, 4'hF, -2, 3'b001, 32'hCAFEF00D, AXI_RESP_SLVERR, 18};
    vecs[4]  = '{0, 4'h0, 32'h0000AB00, 4'h2,  3, 3'b001, 32'hCAFEAB0D, AXI_RESP_OKAY,   5};
    vecs[5]  = '{0, 4'h8, 32'hA5A5A5A5, 4'hC,  1, 3'b100, 32'hA5A50000, AXI_RESP_OKAY,   3};
    vecs[6]  = '{0, 4'h4, 32'hFFFFFFFF, 4'h0, 16, 3'b010, 32'hDEADBEAA, AXI_RESP_OKAY,   18};
    vecs[7]  = '{1, 4'h8, 32'h0, 4'h0, 0, 3'b000, 32'h12345678, AXI_RESP_OKAY,   1};
    vecs[8]  = '{1, 4'hC, 32'h0, 4'h0, 0, 3'b000, 32'h00000000, AXI_RESP_SLVERR, 1};
    vecs[9]  = '{1, 4'h4, 32'h0, 4'h0, 0, 3'b000, 32'h00000000, AXI_RESP_OKAY,   1};
    vecs[10] = '{1, 4'h3, 32'h0, 4'h0, 0, 3'b000, 32'h0F0F0F0F, AXI_RESP_OKAY,   1};

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_rd) begin
        do_read(vecs[i].addr, i % 3, rdat, resp, lat, ok);
        check($sformatf("tbl%0d_rdata", i), rdat, vecs[i].exp_val);
      end else begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].ack_dly, i % 3,
                 en_seen, dseen, resp, lat, ok);
        check($sformatf("tbl%0d_en", i), 32'(en_seen), 32'(vecs[i].exp_en));
        check($sformatf("tbl%0d_wdata", i), dseen, vecs[i].exp_val);
      end
      check($sformatf("tbl%0d_resp", i), 32'(resp), 32'(vecs[i].exp_resp));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("tbl%0d_protocol", i), 32'(ok), 32'd1);
    end

    // Write and read requested together: write first, read held off until bready.
    s_awaddr = 4'h4; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 4'h8; s_arvalid = 1'b1;
    #1;
    check("arb_ready", 32'({s_awready, s_wready, s_arready}), 32'(3'b110));
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("arb_strobe", 32'(reg2ip_en), 32'(3'b010));
    check("arb_strobe_data", reg2ip_data, 32'h0BADF00D);
    step();
    reg2ip_ack = 3'b010;
    step();
    reg2ip_ack = '0;
    check("arb_bvalid", 32'({s_bvalid, s_bresp}), 32'({1'b1, AXI_RESP_OKAY}));
    stable = 1;
    repeat (5) begin
      step();
      if (!s_bvalid || s_bresp !== AXI_RESP_OKAY || s_arready || s_rvalid) stable = 0;
    end
    check("arb_write_stall", 32'(stable), 32'd1);
    s_bready = 1'b1;
    step();
    s_bready = 1'b0;
    check("arb_read_accept", 32'({s_bvalid, s_arready}), 32'(2'b01));
    step();
    s_arvalid = 1'b0;
    check("arb_rvalid", 32'({s_rvalid, s_rresp}), 32'({1'b1, AXI_RESP_OKAY}));
    check("arb_rdata", s_rdata, 32'h12345678);
    stable = 1;
    repeat (5) begin
      step();
      if (!s_rvalid || s_rdata !== 32'h12345678 || s_rresp !== AXI_RESP_OKAY) stable = 0;
    end
    check("arb_read_stall", 32'(stable), 32'd1);
    s_rready = 1'b1;
    step();
    s_rready = 1'b0;
    check("arb_done", 32'(s_rvalid), 32'd0);

    // Reset while waiting for an acknowledge abandons the write.
    s_awaddr = 4'h0; s_wdata = 32'h55AA55AA; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    step();
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    step();
    check("midrst_in_wait", 32'(o_dbg_state), 32'(WR_WAIT));
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_idle("midrst");
    pulses = 0; bv = 0;
    repeat (20) begin
      step();
      if (reg2ip_en != '0) pulses++;
      if (s_bvalid) bv++;
    end
    check("midrst_no_strobe", 32'(pulses), 32'd0);
    check("midrst_no_bvalid", 32'(bv), 32'd0);
    for (int i = 0; i < NUM_REGS; i++) begin m_wr[i] = '0; m_rd[i] = '0; end
    do_write(4'h4, 32'h99887777, 4'h1, 1, 0, en_seen, dseen, resp, lat, ok);
    check("postrst_wdata", dseen, 32'h00000077);
    check("postrst_en", 32'(en_seen), 32'(3'b010));
    check("postrst_resp", 32'(resp), 32'(AXI_RESP_OKAY));
    check("postrst_latency", 32'(lat), 32'd3);
    check("postrst_protocol", 32'(ok), 32'd1);
    m_wr[1] = 32'h00000077;

    // Randomized transactions against the register model.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        rv  = 3'($urandom_range(1, 7));
        rdd = {$urandom, $urandom, $urandom};
        pulse_ip(rv, rdd);
      end
      ra  = 4'($urandom_range(0, 15));
      idx = int'(ra[ADDR_W-1:2]);
      if ($urandom_range(0, 1) == 1) begin
        wd  = $urandom;
        rs  = 4'($urandom_range(0, 15));
        ack = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 4));
        if (idx < NUM_REGS) begin
          ev = merge(m_wr[idx], wd, rs);
          m_wr[idx] = ev;
          eresp = (ack > 0) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
          elat  = (ack > 0) ? 2 + ack : 2 + ACK_TIMEOUT;
        end else begin
          ev = '0; eresp = AXI_RESP_SLVERR; elat = 2;
        end
        exp_q.push_back(ev);
        do_write(ra, wd, rs, ack, int'($urandom_range(0, 3)), en_seen, dseen, resp, lat, ok);
        check("rnd_wdata", dseen, exp_q.pop_front());
        check("rnd_en", 32'(en_seen), (idx < NUM_REGS) ? (32'd1 << idx) : 32'd0);
      end else begin
        ev    = (idx < NUM_REGS) ? m_rd[idx] : '0;
        eresp = (idx < NUM_REGS) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        elat  = 1;
        exp_q.push_back(ev);
        do_read(ra, int'($urandom_range(0, 3)), rdat, resp, lat, ok);
        check("rnd_rdata", rdat, exp_q.pop_front());
      end
      check("rnd_resp", 32'(resp), 32'(eresp));
      check("rnd_latency", 32'(lat), 32'(elat));
      check("rnd_protocol", 32'(ok), 32'd1);
    end

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
